// File: rtl/instr_aligner.sv
// ---------------------------------------------------------------------------
// instr_aligner
//
// Turns a stream of word-aligned 32-bit fetch words into whole instructions
// (16-bit RVC or 32-bit, at any halfword address) and tracks the PC of each.
// A one-halfword residual buffer lets a 32-bit instruction that spans two
// fetch words be reassembled.
//
// Build option:
//   INSTR_ALIGNER_RVC_EN  defined   : full RVC support (residual buffer,
//                                      S_RESID / S_SKIP states).
//                         undefined : every word is a 32-bit instruction,
//                                      pc advances by 4, instr_compressed_o
//                                      is 0, flush targets are word aligned.
//
// Ports:
//   clk_i               clock, rising edge
//   rst_i               synchronous active-high reset
//   fetch_rdata_i[31:0] fetch word, halfword 0 in [15:0]
//   fetch_valid_i       fetch word valid
//   fetch_ready_o       fetch word consumed on valid && ready
//   instr_o[31:0]       aligned instruction ({16'b0, half} when compressed)
//   instr_pc_o[31:0]    PC of instr_o
//   instr_compressed_o  instr_o is 16-bit
//   instr_valid_o       instruction outputs valid
//   instr_ready_i       instruction transfers on valid && ready
//   flush_i             redirect request
//   flush_pc_i[31:0]    redirect target (bit 0 ignored)
//
// State | meaning
// ------+-----------------------------------------------------------------
// S_ALIGNED | next instruction starts at halfword 0 of the fetch word
// S_RESID   | next instruction starts in resid_q (upper half of last word)
// S_SKIP    | post-flush to odd halfword: drop lower half of next word
// ---------------------------------------------------------------------------
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    logic [31:0] pc_q, pc_d;
    logic        xfer;

    assign xfer       = instr_valid_o && instr_ready_i;
    // Reset forces the visible PC immediately, even mid-stream.
    assign instr_pc_o = rst_i ? RESET_PC : pc_q;

`ifdef INSTR_ALIGNER_RVC_EN
    typedef enum logic [1:0] {S_ALIGNED, S_RESID, S_SKIP} state_t;

    state_t      state_q, state_d;
    logic [15:0] resid_q, resid_d;
    logic        fetch_hs;
    logic        unused_flush_bit0;

    assign fetch_hs          = fetch_valid_i && fetch_ready_o;
    assign unused_flush_bit0 = flush_pc_i[0];

    always_comb begin
        instr_valid_o      = 1'b0;
        fetch_ready_o      = 1'b0;
        instr_o            = 32'h0;
        instr_compressed_o = 1'b0;
        if (!rst_i) begin
            if (flush_i) begin
                fetch_ready_o = 1'b1;
            end else begin
                case (state_q)
                    S_ALIGNED: begin
                        instr_valid_o = fetch_valid_i;
                        fetch_ready_o = instr_ready_i;
                        if (fetch_rdata_i[1:0] != 2'b11) begin
                            instr_o            = {16'h0, fetch_rdata_i[15:0]};
                            instr_compressed_o = 1'b1;
                        end else begin
                            instr_o = fetch_rdata_i;
                        end
                    end
                    S_RESID: begin
                        if (resid_q[1:0] != 2'b11) begin
                            // Whole instruction already buffered; hold the fetch word.
                            instr_valid_o      = 1'b1;
                            instr_o            = {16'h0, resid_q};
                            instr_compressed_o = 1'b1;
                        end else begin
                            instr_valid_o = fetch_valid_i;
                            instr_o       = {fetch_rdata_i[15:0], resid_q};
                            fetch_ready_o = instr_ready_i;
                        end
                    end
                    S_SKIP: begin
                        fetch_ready_o = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        resid_d = resid_q;
        if (flush_i) begin
            pc_d    = {flush_pc_i[31:1], 1'b0};
            state_d = flush_pc_i[1] ? S_SKIP : S_ALIGNED;
            resid_d = 16'h0;
        end else begin
            case (state_q)
                S_ALIGNED: begin
                    if (xfer) begin
                        if (instr_compressed_o) begin
                            resid_d = fetch_rdata_i[31:16];
                            pc_d    = pc_q + 32'd2;
                            state_d = S_RESID;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                S_RESID: begin
                    if (xfer) begin
                        if (instr_compressed_o) begin
                            pc_d    = pc_q + 32'd2;
                            state_d = S_ALIGNED;
                        end else begin
                            resid_d = fetch_rdata_i[31:16];
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
                S_SKIP: begin
                    if (fetch_hs) begin
                        resid_d = fetch_rdata_i[31:16];
                        state_d = S_RESID;
                    end
                end
                default: state_d = S_ALIGNED;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_ALIGNED;
            resid_q <= 16'h0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            pc_q    <= pc_d;
        end
    end

`else
    logic unused_flush_low;

    assign unused_flush_low = ^flush_pc_i[1:0];

    always_comb begin
        instr_valid_o      = 1'b0;
        fetch_ready_o      = 1'b0;
        instr_o            = 32'h0;
        instr_compressed_o = 1'b0;
        if (!rst_i) begin
            if (flush_i) begin
                fetch_ready_o = 1'b1;
            end else begin
                instr_valid_o = fetch_valid_i;
                fetch_ready_o = instr_ready_i;
                instr_o       = fetch_rdata_i;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = {flush_pc_i[31:2], 2'b00};
        end else if (xfer) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;

    int checks   = 0;
    int failures = 0;

    instr_aligner #(.RESET_PC(32'h80)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .flush_i            (flush_i),
        .flush_pc_i         (flush_pc_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge and let combinational outputs settle.
    task automatic drive(input logic rst, input logic fv, input logic [31:0] rd,
                         input logic ir, input logic fl, input logic [31:0] fpc);
        rst_i         = rst;
        fetch_valid_i = fv;
        fetch_rdata_i = rd;
        instr_ready_i = ir;
        flush_i       = fl;
        flush_pc_i    = fpc;
        #2;
    endtask

    task automatic outs(input string tag, input logic v, input logic fr,
                        input logic [31:0] ins, input logic [31:0] pc, input logic c);
        chk({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, v});
        chk({tag, ".frdy"},  {31'h0, fetch_ready_o}, {31'h0, fr});
        chk({tag, ".instr"}, instr_o, ins);
        chk({tag, ".pc"},    instr_pc_o, pc);
        chk({tag, ".comp"},  {31'h0, instr_compressed_o}, {31'h0, c});
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("reset", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0);
        cyc();

        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("first", 1'b1, 1'b1, 32'h0051_0093, 32'h80, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("first.nextpc", instr_pc_o, 32'h84);

`ifdef INSTR_ALIGNER_RVC_EN
        // Flush to 0, then two compressed halves in one word.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        outs("flush0", 1'b0, 1'b1, 32'h0, 32'h84, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0);
        outs("cc.lo", 1'b1, 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        outs("cc.hi", 1'b1, 1'b0, 32'h0000_4585, 32'h2, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("cc.nextpc", instr_pc_o, 32'h4);

        // Spanning instruction, with a 5-cycle stall in S_RESID.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        cyc();
        drive(1'b0, 1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0);
        outs("sp.c0", 1'b1, 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h4585_0051, 1'b0, 1'b0, 32'h0);
            outs("stall", 1'b1, 1'b0, 32'h0051_0093, 32'h2, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b1, 32'h4585_0051, 1'b1, 1'b0, 32'h0);
        outs("sp.span", 1'b1, 1'b1, 32'h0051_0093, 32'h2, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        outs("sp.c1", 1'b1, 1'b0, 32'h0000_4585, 32'h6, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("sp.nextpc", instr_pc_o, 32'h8);

        // Flush to odd halfword coincident with a valid handshake.
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b1, 32'h102);
        outs("flush102", 1'b0, 1'b1, 32'h0, 32'h8, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 32'h0093_1234, 1'b1, 1'b0, 32'h0);
        outs("skip", 1'b0, 1'b1, 32'h0, 32'h102, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 32'hABCD_0051, 1'b1, 1'b0, 32'h0);
        outs("skip.span", 1'b1, 1'b1, 32'h0051_0093, 32'h102, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        outs("skip.c", 1'b1, 1'b0, 32'h0000_ABCD, 32'h106, 1'b1);
        cyc();

        // PC wrap through 0xFFFF_FFFE.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        cyc();
        drive(1'b0, 1'b1, 32'h0001_1111, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        outs("wrap", 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap.pc", instr_pc_o, 32'h0);

        // Flush bit 0 ignored.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h201);
        cyc();
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("odd", 1'b1, 1'b1, 32'h0051_0093, 32'h200, 1'b0);
        cyc();
`else
        drive(1'b0, 1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0);
        outs("w32", 1'b1, 1'b1, 32'h4585_4501, 32'h84, 1'b0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h0093_4501, 1'b0, 1'b0, 32'h0);
            outs("stall", 1'b1, 1'b0, 32'h0093_4501, 32'h88, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b1, 32'h102);
        outs("flush102", 1'b0, 1'b1, 32'h0, 32'h88, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("post", 1'b1, 1'b1, 32'h0051_0093, 32'h100, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        cyc();
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("wrap", 1'b1, 1'b1, 32'h0051_0093, 32'hFFFF_FFFC, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap.pc", instr_pc_o, 32'h0);
        drive(1'b0, 1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0);
        cyc();
`endif

        // Reset mid-stream overrides flush and handshake.
        drive(1'b1, 1'b1, 32'h0051_0093, 1'b1, 1'b1, 32'h300);
        outs("midrst", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 32'h0051_0093, 1'b1, 1'b0, 32'h0);
        outs("postrst", 1'b1, 1'b1, 32'h0051_0093, 32'h80, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
